mux_arb: RTL and testbench



---
 rtl/mux_arb_if.sv | 26 ++
 rtl/mux_arb.sv | 128 ++++++++++++
 tb/tb_mux_arb.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_if.sv
// rtl/mux_arb_if.sv - producer-side and consumer-side signals of mux_arb
interface mux_arb_if #(
   parameter int NCH = 2,
   parameter int DW  = 32,
   parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
);
   logic [NCH*DW-1:0] in_data;
   logic [NCH-1:0]    in_sel;
   logic [NCH-1:0]    in_ack;
   logic [DW-1:0]     out_data;
   logic              out_resp;
   logic [CW-1:0]     out_chan;
   logic              out_ready;

   // master: producers plus downstream consumer (drive requests and ready)
   modport master (
      output in_data, in_sel, out_ready,
      input  in_ack, out_data, out_resp, out_chan
   );

   // slave: the arbiter itself
   modport slave (
      input  in_data, in_sel, out_ready,
      output in_ack, out_data, out_resp, out_chan
   );
endinterface

// File: rtl/mux_arb.sv
// rtl/mux_arb.sv - round-robin N-channel arbiter with registered output; MUX_ARB_FIXED_PRI_EN selects fixed priority
module mux_arb #(
   parameter int NCH   = 2,
   parameter int DW    = 32,
   parameter int BURST = 1
) (
   input  logic       clk,
   input  logic       reset,
   mux_arb_if.slave   bus
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [DW-1:0]   r_data;
   logic [CW-1:0]   r_chan;

   logic            w_load_en;
   logic            w_gnt_vld;
   logic [CW-1:0]   w_gnt;
   logic            w_fire;

   // the output register can take a new word when empty or being drained this cycle
   assign w_load_en = (r_state == ST_EMPTY) || bus.out_ready;
   assign w_fire    = w_load_en && w_gnt_vld && !reset;

`ifdef MUX_ARB_FIXED_PRI_EN
   // lowest-index requester wins; scanning downward leaves the lowest hit last
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (bus.in_sel[k]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = CW'(k);
         end
      end
   end
`else
   localparam logic [CW:0]   NCH_W   = (CW + 1)'(NCH);
   localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);
   localparam logic [7:0]    BURST_W = 8'(BURST);

   logic [CW-1:0]    r_ptr;
   logic [CW-1:0]    r_last;
   logic [7:0]       r_cnt;
   logic [2*NCH-1:0] w_sel2;
   logic [NCH-1:0]   w_rot;
   logic [CW-1:0]    w_off;
   logic [CW:0]      w_sum;
   logic [7:0]       w_cnt_nxt;
   logic [CW-1:0]    w_gnt_inc;

   // rotate requests so the pointer sits at bit 0, take the lowest hit, rotate back
   always_comb begin
      w_sel2    = {bus.in_sel, bus.in_sel} >> r_ptr;
      w_rot     = w_sel2[NCH-1:0];
      w_gnt_vld = |w_rot;
      w_off     = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = CW'(k);
      end
      w_sum = {1'b0, r_ptr} + {1'b0, w_off};
      if (w_sum >= NCH_W) w_sum = w_sum - NCH_W;
      w_gnt = w_sum[CW-1:0];
   end

   assign w_cnt_nxt = (w_gnt == r_last) ? (r_cnt + 8'd1) : 8'd1;
   assign w_gnt_inc = (w_gnt == LAST_CH) ? '0 : (w_gnt + 1'b1);

   // burst bookkeeping: stay on the granted channel until it has had BURST words
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr  <= '0;
         r_last <= '0;
         r_cnt  <= '0;
      end else if (w_fire) begin
         r_last <= w_gnt;
         if (w_cnt_nxt >= BURST_W) begin
            r_ptr <= w_gnt_inc;
            r_cnt <= '0;
         end else begin
            r_ptr <= w_gnt;
            r_cnt <= w_cnt_nxt;
         end
      end
   end
`endif

   // one-hot acknowledge for the channel whose word is captured at the next edge
   always_comb begin
      bus.in_ack = '0;
      if (w_fire) bus.in_ack[w_gnt] = 1'b1;
   end

   // output-stage next state: fill on a grant, empty when drained with nothing new
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_fire) w_state_nxt = ST_FULL;
         ST_FULL:  if (bus.out_ready) w_state_nxt = w_gnt_vld ? ST_FULL : ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   // output-stage state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_EMPTY;
      else       r_state <= w_state_nxt;
   end

   // capture the granted word and its channel index
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data <= '0;
         r_chan <= '0;
      end else if (w_fire) begin
         r_data <= bus.in_data[int'(w_gnt) * DW +: DW];
         r_chan <= w_gnt;
      end
   end

   assign bus.out_data = r_data;
   assign bus.out_resp = (r_state == ST_FULL);
   assign bus.out_chan = r_chan;
endmodule

// File: tb/tb_mux_arb.sv
// tb/tb_mux_arb.sv - directed table-driven bench for mux_arb (2-channel and 4-channel instances)
module tb_mux_arb;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_pass = 0;
   int   n_tot  = 0;

   always #5 clk = ~clk;

   mux_arb_if #(.NCH(2), .DW(32)) b2 ();
   mux_arb_if #(.NCH(4), .DW(32)) b4 ();

   mux_arb #(.NCH(2), .DW(32), .BURST(1)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
   mux_arb #(.NCH(4), .DW(32), .BURST(3)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));

   typedef struct {
      logic       d4;
      logic       rst;
      logic [3:0] sel;
      logic       rdy;
      logic [3:0] ack;
      logic       resp;
      logic [1:0] chan;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic d4, input logic rst, input logic [3:0] sel,
                               input logic rdy, input logic [3:0] ack, input logic resp,
                               input logic [1:0] chan);
      vec_t v;
      v.d4 = d4; v.rst = rst; v.sel = sel; v.rdy = rdy;
      v.ack = ack; v.resp = resp; v.chan = chan;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic pulse_reset();
      b2.in_sel = '0;
      b4.in_sel = '0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      logic [31:0] exp_data;
      logic [3:0]  a_ack;
      logic        a_resp;
      logic [1:0]  a_chan;
      logic [31:0] a_data;

      b2.in_data   = {32'd1234, 32'd4096};
      b4.in_data   = {32'd103, 32'd102, 32'd101, 32'd100};
      b2.in_sel    = 2'b01;
      b4.in_sel    = 4'b1111;
      b2.out_ready = 1'b1;
      b4.out_ready = 1'b1;

      // reset state, with requests present so the ack gating is exercised
      #12;
      check("rst ack2",  32'(b2.in_ack), 32'd0);
      check("rst ack4",  32'(b4.in_ack), 32'd0);
      check("rst resp2", 32'(b2.out_resp), 32'd0);
      check("rst data2", b2.out_data, 32'd0);
      check("rst chan2", 32'(b2.out_chan), 32'd0);
      check("rst resp4", 32'(b4.out_resp), 32'd0);
      check("rst data4", b4.out_data, 32'd0);
      check("rst chan4", 32'(b4.out_chan), 32'd0);
      b2.in_sel = '0;
      b4.in_sel = '0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // single word through, then drain to empty
      vq.push_back(mk(0, 1, 4'b0001, 1, 4'b0001, 0, 0));
      vq.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 1, 0));
      vq.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 0, 0));
`ifndef MUX_ARB_FIXED_PRI_EN
      // two channels alternating, then a 5-cycle stall while full
      vq.push_back(mk(0, 1, 4'b0011, 1, 4'b0001, 0, 0));
      vq.push_back(mk(0, 0, 4'b0011, 1, 4'b0010, 1, 0));
      vq.push_back(mk(0, 0, 4'b0011, 1, 4'b0001, 1, 1));
      vq.push_back(mk(0, 0, 4'b0011, 1, 4'b0010, 1, 0));
      vq.push_back(mk(0, 0, 4'b0011, 1, 4'b0001, 1, 1));
      for (int i = 0; i < 5; i++) vq.push_back(mk(0, 0, 4'b0011, 0, 4'b0000, 1, 0));
      vq.push_back(mk(0, 0, 4'b0011, 1, 4'b0010, 1, 0));
      vq.push_back(mk(0, 0, 4'b0011, 1, 4'b0001, 1, 1));
      vq.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 1, 0));
      vq.push_back(mk(0, 0, 4'b0000, 1, 4'b0000, 0, 0));
      // four channels, burst of 3, all requesting
      begin
         logic [1:0] seq [13];
         seq = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
         for (int i = 0; i < 13; i++)
            vq.push_back(mk(1, (i == 0), 4'b1111, 1, 4'(1 << seq[i]), (i != 0),
                            (i == 0) ? 2'd0 : seq[i-1]));
         vq.push_back(mk(1, 0, 4'b0000, 1, 4'b0000, 1, 0));
         vq.push_back(mk(1, 0, 4'b0000, 1, 4'b0000, 0, 0));
      end
      // channel 1 withdraws after its first grant
      vq.push_back(mk(1, 1, 4'b1111, 1, 4'b0001, 0, 0));
      vq.push_back(mk(1, 0, 4'b1111, 1, 4'b0001, 1, 0));
      vq.push_back(mk(1, 0, 4'b1111, 1, 4'b0001, 1, 0));
      vq.push_back(mk(1, 0, 4'b1111, 1, 4'b0010, 1, 0));
      vq.push_back(mk(1, 0, 4'b1101, 1, 4'b0100, 1, 1));
      vq.push_back(mk(1, 0, 4'b1101, 1, 4'b0100, 1, 2));
      vq.push_back(mk(1, 0, 4'b1101, 1, 4'b0100, 1, 2));
      vq.push_back(mk(1, 0, 4'b1101, 1, 4'b1000, 1, 2));
      vq.push_back(mk(1, 0, 4'b0000, 1, 4'b0000, 1, 3));
`else
      // fixed priority: channel 1 starves channel 3 until it drops
      vq.push_back(mk(1, 1, 4'b1010, 1, 4'b0010, 0, 0));
      vq.push_back(mk(1, 0, 4'b1010, 1, 4'b0010, 1, 1));
      vq.push_back(mk(1, 0, 4'b1010, 1, 4'b0010, 1, 1));
      vq.push_back(mk(1, 0, 4'b1000, 1, 4'b1000, 1, 1));
      vq.push_back(mk(1, 0, 4'b1000, 1, 4'b1000, 1, 3));
      vq.push_back(mk(1, 0, 4'b0000, 1, 4'b0000, 1, 3));
      vq.push_back(mk(1, 0, 4'b0000, 1, 4'b0000, 0, 0));
`endif

      foreach (vq[i]) begin
         v = vq[i];
         if (v.rst) pulse_reset();
         if (v.d4) begin
            b4.in_sel = v.sel; b4.out_ready = v.rdy; b2.in_sel = '0;
         end else begin
            b2.in_sel = v.sel[1:0]; b2.out_ready = v.rdy; b4.in_sel = '0;
         end
         @(negedge clk);
         if (v.d4) begin
            a_ack = b4.in_ack; a_resp = b4.out_resp; a_chan = b4.out_chan; a_data = b4.out_data;
            exp_data = 32'd100 + 32'(v.chan);
         end else begin
            a_ack = {2'b00, b2.in_ack}; a_resp = b2.out_resp; a_chan = {1'b0, b2.out_chan};
            a_data = b2.out_data;
            exp_data = v.chan[0] ? 32'd1234 : 32'd4096;
         end
         check($sformatf("row%0d ack", i), 32'(a_ack), 32'(v.ack));
         check($sformatf("row%0d resp", i), 32'(a_resp), 32'(v.resp));
         if (v.resp) begin
            check($sformatf("row%0d chan", i), 32'(a_chan), 32'(v.chan));
            check($sformatf("row%0d data", i), a_data, exp_data);
         end
         @(posedge clk);
         #1;
      end

      // asynchronous reset while a word is held, then first grant restarts at ch0
      pulse_reset();
      b4.in_sel    = '0;
      b2.in_data   = {32'd1234, 32'd5678};
      b2.out_ready = 1'b0;
      b2.in_sel    = 2'b01;
      @(posedge clk);
      #1;
      b2.in_sel = 2'b00;
      check("held resp", 32'(b2.out_resp), 32'd1);
      check("held data", b2.out_data, 32'd5678);
      #2;
      reset = 1'b1;
      #1;
      b2.in_sel  = 2'b11;
      b2.in_data = {32'd1234, 32'd4096};
      #1;
      check("async resp", 32'(b2.out_resp), 32'd0);
      check("async data", b2.out_data, 32'd0);
      check("async chan", 32'(b2.out_chan), 32'd0);
      check("async ack",  32'(b2.in_ack), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      b2.out_ready = 1'b1;
      #1;
      check("post ack", 32'(b2.in_ack), 32'd1);
      @(posedge clk);
      #1;
      b2.in_sel = 2'b00;
      check("post data", b2.out_data, 32'd4096);
      check("post chan", 32'(b2.out_chan), 32'd0);
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
